// File: rtl/ahb_image_slave.sv
// Memory-side responder for the simplified AHB bus: word-addressed image store with a
// fixed number of wait states per transfer, sticky range error flag and write counter.
module ahb_image_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        herr,
    output logic [15:0] write_count
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [2:0] CNT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    logic [31:0]      mem [DEPTH];
    logic [1:0]       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic             write_q;
    logic             in_range_q;

    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             accept;
    logic             completing;
    logic             wr_commit;
    logic             rd_load;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_in_range;
    logic             fwd;
    logic [31:0]      rd_data;
    logic             unused_addr_bits;

    assign offset           = haddr - ADDR_BASE;
    assign idx              = offset[IDX_W+1:2];
    assign in_range         = (haddr >= ADDR_BASE) && ({2'b00, offset[31:2]} < DEPTH);
    assign unused_addr_bits = ^offset[1:0];

    assign hready     = (state_q != WAIT);
    assign accept     = hsel && hready;
    assign completing = (state_q == DONE);
    assign wr_commit  = completing && write_q && in_range_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
        endcase
        // A new address phase overrides the DONE->IDLE exit for back-to-back pipelining.
        if (accept) begin
            state_d = (WAIT_STATES > 0) ? WAIT : DONE;
            cnt_d   = CNT_LOAD;
        end
    end

    // Read data is registered on the edge entering the completion cycle; with no wait
    // states that edge is the address phase itself, so the live address is used.
    always_comb begin
        if (WAIT_STATES == 0) begin
            rd_load     = accept && !hwrite;
            rd_idx      = idx;
            rd_in_range = in_range;
        end else begin
            rd_load     = (state_q == WAIT) && (cnt_q == 3'd0) && !write_q;
            rd_idx      = idx_q;
            rd_in_range = in_range_q;
        end
        fwd = wr_commit && (idx_q == rd_idx);
        if (!rd_in_range) begin
            rd_data = 32'hDEAD_BEEF;
        end else if (fwd) begin
            rd_data = hwdata;
        end else begin
            rd_data = mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            in_range_q  <= 1'b0;
            hrdata      <= 32'h0;
            herr        <= 1'b0;
            write_count <= 16'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q      <= idx;
                write_q    <= hwrite;
                in_range_q <= in_range;
            end
            if (rd_load) begin
                hrdata <= rd_data;
            end
            if (completing && !in_range_q) begin
                herr <= 1'b1;
            end
            if (wr_commit && (write_count != 16'hFFFF)) begin
                write_count <= write_count + 16'd1;
            end
        end
    end

    // Contents survive reset; a write caught by reset is dropped.
    always_ff @(posedge clk) begin
        if (n_rst && wr_commit) begin
            mem[idx_q] <= hwdata;
        end
    end

endmodule

// File: tb/tb_ahb_image_slave.sv
// Bench for ahb_image_slave: three instances (1, 0 and 3 wait states) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_ahb_image_slave;

    localparam int N     = 3;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst       [N];
    logic        hsel        [N];
    logic [31:0] haddr       [N];
    logic        hwrite      [N];
    logic [31:0] hwdata      [N];
    logic [31:0] hrdata      [N];
    logic        hready      [N];
    logic        herr        [N];
    logic [15:0] write_count [N];

    ahb_image_slave #(.ADDR_BASE(32'h0), .DEPTH(DEPTH), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .n_rst(n_rst[0]), .hsel(hsel[0]), .haddr(haddr[0]), .hwrite(hwrite[0]),
        .hwdata(hwdata[0]), .hrdata(hrdata[0]), .hready(hready[0]), .herr(herr[0]),
        .write_count(write_count[0])
    );
    ahb_image_slave #(.ADDR_BASE(32'h0), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .n_rst(n_rst[1]), .hsel(hsel[1]), .haddr(haddr[1]), .hwrite(hwrite[1]),
        .hwdata(hwdata[1]), .hrdata(hrdata[1]), .hready(hready[1]), .herr(herr[1]),
        .write_count(write_count[1])
    );
    ahb_image_slave #(.ADDR_BASE(32'h0), .DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .n_rst(n_rst[2]), .hsel(hsel[2]), .haddr(haddr[2]), .hwrite(hwrite[2]),
        .hwdata(hwdata[2]), .hrdata(hrdata[2]), .hready(hready[2]), .herr(herr[2]),
        .write_count(write_count[2])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ws_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    // Model: one outstanding transfer per instance, counting down the cycles left until
    // its completion cycle; a read's data is the memory image at the edge entering it.
    bit          m_ok     [N];
    bit          m_pend   [N];
    int          m_left   [N];
    bit          m_wr     [N];
    bit          m_inr    [N];
    int          m_idx    [N];
    logic [31:0] m_mem    [N][DEPTH];
    bit          m_vld    [N][DEPTH];
    logic [31:0] m_rdata  [N];
    bit          m_rknown [N];
    bit          m_ready  [N];
    bit          m_err    [N];
    int          m_wcount [N];

    task automatic model_load(input int i);
        if (!m_inr[i]) begin
            m_rdata[i]  = 32'hDEAD_BEEF;
            m_rknown[i] = 1'b1;
        end else begin
            m_rdata[i]  = m_mem[i][m_idx[i]];
            m_rknown[i] = m_vld[i][m_idx[i]];
        end
    endtask

    task automatic model_step(input int i);
        if (!n_rst[i]) begin
            m_ok[i]     = 1'b1;
            m_pend[i]   = 1'b0;
            m_rdata[i]  = 32'h0;
            m_rknown[i] = 1'b1;
            m_ready[i]  = 1'b1;
            m_err[i]    = 1'b0;
            m_wcount[i] = 0;
        end else if (m_ok[i]) begin
            if (m_pend[i] && m_left[i] == 0) begin
                if (!m_inr[i]) begin
                    m_err[i] = 1'b1;
                end else if (m_wr[i]) begin
                    m_mem[i][m_idx[i]] = hwdata[i];
                    m_vld[i][m_idx[i]] = 1'b1;
                    if (m_wcount[i] < 65535) m_wcount[i]++;
                end
                m_pend[i] = 1'b0;
            end else if (m_pend[i]) begin
                m_left[i]--;
                if (m_left[i] == 0 && !m_wr[i]) model_load(i);
            end
            if (hsel[i] && m_ready[i]) begin
                m_pend[i] = 1'b1;
                m_left[i] = ws_of(i);
                m_wr[i]   = hwrite[i];
                m_inr[i]  = (haddr[i] >> 2) < DEPTH;
                m_idx[i]  = int'(haddr[i] >> 2) % DEPTH;
                if (m_left[i] == 0 && !m_wr[i]) model_load(i);
            end
            m_ready[i] = !(m_pend[i] && m_left[i] > 0);
        end
    endtask

    initial forever begin
        @(posedge clk);
        for (int i = 0; i < N; i++) model_step(i);
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (m_ok[i]) begin
                check($sformatf("u%0d.hready", i), 32'(hready[i]), 32'(m_ready[i]));
                check($sformatf("u%0d.herr", i), 32'(herr[i]), 32'(m_err[i]));
                check($sformatf("u%0d.write_count", i), 32'(write_count[i]), m_wcount[i]);
                if (m_rknown[i]) check($sformatf("u%0d.hrdata", i), hrdata[i], m_rdata[i]);
            end
        end
    end

    // Starts at posedge+2 with the instance idle; returns at posedge+2 after completion.
    task automatic do_xfer(input int i, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, output int low, output logic [31:0] rd);
        hsel[i]   = 1'b1;
        hwrite[i] = wr;
        haddr[i]  = addr;
        hwdata[i] = wr ? data : 32'h0BAD_0BAD;
        @(posedge clk); #2;
        hsel[i]   = 1'b0;
        hwrite[i] = !wr;
        haddr[i]  = 32'hFFFF_FFFC;
        low = 0;
        while (!hready[i] && low < 16) begin
            low++;
            @(posedge clk); #2;
        end
        if (low >= 16) check($sformatf("u%0d.completion_timeout", i), 32'(low), 32'(ws_of(i)));
        rd = hrdata[i];
        @(posedge clk); #2;
    endtask

    int          low;
    logic [31:0] rd;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            n_rst[i] = 1'b0; hsel[i] = 1'b0; haddr[i] = 32'h0; hwrite[i] = 1'b0;
            hwdata[i] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) n_rst[i] = 1'b1;

        // Reset and idle
        repeat (3) begin
            @(posedge clk); #2;
            check("idle.hready", 32'(hready[0]), 32'h1);
            check("idle.hrdata", hrdata[0], 32'h0);
            check("idle.herr", 32'(herr[0]), 32'h0);
            check("idle.write_count", 32'(write_count[0]), 32'h0);
        end

        // Write then read, one wait state
        do_xfer(0, 1'b1, 32'h10, 32'h00FF_8040, low, rd);
        check("wr.wait_cycles", low, 1);
        do_xfer(0, 1'b0, 32'h10, 32'h0, low, rd);
        check("rd.wait_cycles", low, 1);
        check("rd.hrdata", rd, 32'h00FF_8040);
        check("rd.write_count", 32'(write_count[0]), 32'h1);

        // Back-to-back write/read with forwarding, zero wait states
        hsel[1] = 1'b1; hwrite[1] = 1'b1; haddr[1] = 32'h20; hwdata[1] = 32'h0;
        check("b2b.hready_a", 32'(hready[1]), 32'h1);
        @(posedge clk); #2;
        hwrite[1] = 1'b0; haddr[1] = 32'h20; hwdata[1] = 32'hA5A5_0001;
        check("b2b.hready_b", 32'(hready[1]), 32'h1);
        @(posedge clk); #2;
        hsel[1] = 1'b0; hwdata[1] = 32'h0;
        check("b2b.hready_c", 32'(hready[1]), 32'h1);
        check("b2b.hrdata", hrdata[1], 32'hA5A5_0001);
        @(posedge clk); #2;
        check("b2b.write_count", 32'(write_count[1]), 32'h1);

        // Out of range
        do_xfer(0, 1'b1, 32'h1000, 32'h1234_5678, low, rd);
        check("oor.wait_cycles", low, 1);
        check("oor.herr", 32'(herr[0]), 32'h1);
        check("oor.write_count", 32'(write_count[0]), 32'h1);
        do_xfer(0, 1'b0, 32'h1000, 32'h0, low, rd);
        check("oor.hrdata", rd, 32'hDEAD_BEEF);
        do_xfer(0, 1'b1, 32'h14, 32'h5555_AAAA, low, rd);
        do_xfer(0, 1'b0, 32'h14, 32'h0, low, rd);
        check("oor.inrange_rd", rd, 32'h5555_AAAA);
        check("oor.herr_sticky", 32'(herr[0]), 32'h1);
        check("oor.write_count2", 32'(write_count[0]), 32'h2);

        // Wait-state sweep, three wait states
        do_xfer(2, 1'b1, 32'h0, 32'hCAFE_F00D, low, rd);
        check("ws3.wr_wait_cycles", low, 3);
        do_xfer(2, 1'b0, 32'h0, 32'h0, low, rd);
        check("ws3.rd_wait_cycles", low, 3);
        check("ws3.hrdata", rd, 32'hCAFE_F00D);

        // Reset during the second wait cycle of a write
        do_xfer(2, 1'b1, 32'h40, 32'h1111_2222, low, rd);
        hsel[2] = 1'b1; hwrite[2] = 1'b1; haddr[2] = 32'h40; hwdata[2] = 32'h9999_0000;
        @(posedge clk); #2;
        hsel[2] = 1'b0;
        check("rst.wait1_hready", 32'(hready[2]), 32'h0);
        @(posedge clk); #2;
        n_rst[2] = 1'b0;
        @(posedge clk); #2;
        n_rst[2] = 1'b1;
        @(posedge clk); #2;
        check("rst.hready_after", 32'(hready[2]), 32'h1);
        check("rst.write_count", 32'(write_count[2]), 32'h0);
        check("rst.hrdata", hrdata[2], 32'h0);
        do_xfer(2, 1'b0, 32'h40, 32'h0, low, rd);
        check("rst.rd_wait_cycles", low, 3);
        check("rst.hrdata_prewrite", rd, 32'h1111_2222);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_image_slave.md
Name: ahb_image_slave

Overview:
- Bus responder (memory side) of the team's simplified AHB interface. It serves the edge-detection engine's read and write traffic on haddr/hwrite/hwdata/hrdata/hready.
- Holds a word-addressed image memory and inserts a programmable number of wait states per transfer.
- Used as the system memory model in top-level benches. It is also the synthesizable on-chip frame store for the FPGA build.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte address of memory word 0.
- DEPTH, 1024, number of 32-bit words.
- WAIT_STATES, 1, hready-low cycles inserted per transfer; legal range 0..7.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, synchronous, active-low
- hsel  in  1  transfer request, qualifies the address phase
- haddr  in  32  byte address; bits [1:0] ignored
- hwrite  in  1  1 = write, 0 = read; sampled in the address phase
- hwdata  in  32  write data; sampled only in the completion cycle
- hrdata  out  32  read data, registered
- hready  out  1  1 = current data phase completes this cycle and a new address phase may be accepted
- herr  out  1  sticky out-of-range access flag
- write_count  out  16  number of committed in-range writes, saturating

Behaviour:
- Interface: one clock, clk; reset n_rst is synchronous and active-low.
- Reset (n_rst=0 at a rising edge):
  - hready=1, hrdata=0, herr=0, write_count=0, FSM=IDLE.
  - Memory contents are not reset.
- Address phase: any cycle with hsel=1 and hready=1.
  - Latch haddr, hwrite and the range check at that edge.
  - index = (haddr - ADDR_BASE) >> 2.
  - In range iff haddr >= ADDR_BASE and index < DEPTH.
  - hsel=0 means no transfer; hready stays 1.
- FSM states IDLE, WAIT, DONE:
  - IDLE: on an accepted address phase, go to WAIT if WAIT_STATES>0, else DONE.
  - WAIT: hready=0. A down-counter loaded with WAIT_STATES-1 decrements each cycle; at 0 go to DONE.
  - DONE (completion cycle): hready=1.
    - If hsel=1, a new address phase is accepted in the same cycle (back-to-back pipelining); go to WAIT or DONE per the rule above.
    - Otherwise go to IDLE.
- Latency: N = WAIT_STATES. The completion cycle is address-phase cycle + N + 1.
- Writes:
  - hwdata is committed at the rising edge that ends the completion cycle.
  - write_count increments at the same edge, saturating at 16'hFFFF.
- Reads:
  - hrdata is loaded at the edge entering the completion cycle and is valid while hready=1 in DONE.
  - hrdata holds its value otherwise.
- Out of range:
  - Writes are discarded and write_count does not increment.
  - Reads return 32'hDEAD_BEEF.
  - herr is set at the completion edge and stays set until reset.
  - Timing and hready behaviour are unchanged.
- Read-after-write hazard (WAIT_STATES=0):
  - Applies when a read's address phase coincides with a write's completion cycle to the same index.
  - hrdata must return that cycle's hwdata (forwarding), not stale memory.
- Reset mid-transfer:
  - A pending write is abandoned (not committed).
  - hready=1 in the cycle after reset release; no stale hrdata update.
- hwrite/haddr changes outside address phases are ignored.
- hwdata is ignored for reads.

Test Plan:
- Reset and idle, WAIT_STATES=1: hold n_rst=0 for 2 cycles, then hsel=0 -> hready=1, hrdata=0, herr=0, write_count=0 continuously.
- Write then read, WAIT_STATES=1:
  - Write 32'h00FF_8040 to haddr 32'h10, then read 32'h10.
  - Each transfer shows hready=0 for exactly 1 cycle.
  - Read completion cycle shows hrdata=32'h00FF_8040; write_count=1.
- Back-to-back, WAIT_STATES=0:
  - Write 32'hA5A5_0001 to 0x20 followed immediately by a read of 0x20 (hsel held high).
  - hready never drops; read returns 32'hA5A5_0001 via forwarding.
- Out of range, DEPTH=1024:
  - Write to byte address 32'h1000 (index 1024) -> herr=1 from the completion edge, write_count unchanged.
  - Subsequent read of 32'h1000 returns 32'hDEAD_BEEF; herr remains 1 through later in-range transfers.
- Wait-state sweep: WAIT_STATES=3, read of 0x0 -> hready low for exactly 3 cycles, completion on cycle 4 after the address phase.
- Reset mid-write: WAIT_STATES=3, assert n_rst=0 during the 2nd WAIT cycle of a write to 0x40.
  - Later read of 0x40 returns the pre-write contents.
  - write_count=0 and hready=1 in the cycle after reset release.
